// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sequencing one shared 16-bit ALU evaluation per transaction
// Optional feature macro: ALU_ARB_FIXED_PRIO_EN (fixed priority, requester 0 always wins ties).
module alu_arbiter #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_ain,
  input  logic [DATA_W-1:0] req0_bin,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req1_ain,
  input  logic [DATA_W-1:0] req1_bin,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_out,
  output logic [2:0]        rsp_flags,
  output logic [DATA_W-1:0] alu_ain,
  output logic [DATA_W-1:0] alu_bin,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_v,
  output logic              busy,
  output logic [15:0]       ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              id_q, id_d;
  logic [DATA_W-1:0] ain_q, ain_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [2:0]        flags_q, flags_d;
  logic [15:0]       ops_done_q, ops_done_d;

  logic [1:0]        grant;
  logic              sel_id;

  // Pick the winning requester from the currently valid set.
  always_comb begin
    grant = 2'b00;
`ifdef ALU_ARB_FIXED_PRIO_EN
    if (req_valid[0]) begin
      grant = 2'b01;
    end else if (req_valid[1]) begin
      grant = 2'b10;
    end
`else
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie the requester that did not win last time goes next.
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
`endif
  end

  assign sel_id    = grant[1];
  assign req_ready = (state_q == IDLE) ? grant : 2'b00;

  // Next-state and datapath capture for the accept/evaluate/respond sequence.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    ain_d      = ain_q;
    bin_d      = bin_q;
    op_d       = op_q;
    out_d      = out_q;
    flags_d    = flags_q;
    ops_done_d = ops_done_q;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          ain_d   = sel_id ? req1_ain : req0_ain;
          bin_d   = sel_id ? req1_bin : req0_bin;
          op_d    = sel_id ? req1_op  : req0_op;
          id_d    = sel_id;
          last_d  = sel_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Operands have been stable on the ALU for the whole cycle; sample its result.
        out_d   = alu_out;
        flags_d = {alu_z, alu_n, alu_v};
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          ops_done_d = ops_done_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-data registers; reset discards any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      id_q       <= 1'b0;
      ain_q      <= '0;
      bin_q      <= '0;
      op_q       <= '0;
      out_q      <= '0;
      flags_q    <= 3'b000;
      ops_done_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      id_q       <= id_d;
      ain_q      <= ain_d;
      bin_q      <= bin_d;
      op_q       <= op_d;
      out_q      <= out_d;
      flags_q    <= flags_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_out   = out_q;
  assign rsp_flags = flags_q;
  assign alu_ain   = ain_q;
  assign alu_bin   = bin_q;
  assign alu_op    = op_q;
  assign busy      = (state_q != IDLE);
  assign ops_done  = ops_done_q;

endmodule
